// File: rtl/fpu_exception_responder_if.sv
// Handshake and data bundle between the exception detector / datapath and the
// FPU result port. The responder uses the slave view; the producer uses master.
interface fpu_exception_responder_if;
    logic       IN_VALID;
    logic       IN_READY;
    logic [1:0] FP_OPERATION;
    logic [7:0] OP_A;
    logic [7:0] OP_B;
    logic       OP_IS_EXCEPTION;
    logic [2:0] FP_EXCE;
    logic [7:0] NORMAL_RESULT;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] RESULT;
    logic [2:0] RESULT_EXCE;
    logic       FLAG_CLR;
    logic [2:0] STICKY_FLAGS;
    logic [2:0] TRAP_EN;
    logic       TRAP_REQ;
    logic [2:0] TRAP_CAUSE;
    logic       TRAP_ACK;

    modport master (
        output IN_VALID, FP_OPERATION, OP_A, OP_B, OP_IS_EXCEPTION, FP_EXCE,
               NORMAL_RESULT, OUT_READY, FLAG_CLR, TRAP_EN, TRAP_ACK,
        input  IN_READY, OUT_VALID, RESULT, RESULT_EXCE, STICKY_FLAGS,
               TRAP_REQ, TRAP_CAUSE
    );

    modport slave (
        input  IN_VALID, FP_OPERATION, OP_A, OP_B, OP_IS_EXCEPTION, FP_EXCE,
               NORMAL_RESULT, OUT_READY, FLAG_CLR, TRAP_EN, TRAP_ACK,
        output IN_READY, OUT_VALID, RESULT, RESULT_EXCE, STICKY_FLAGS,
               TRAP_REQ, TRAP_CAUSE
    );
endinterface

// File: rtl/fpu_exception_responder.sv
// Registered responder turning detector verdicts into IEEE-style special results,
// sticky status flags and an optional trap request/acknowledge hold.
//
//   state | meaning
//   EMPTY | output register empty
//   FULL  | result presented on RESULT/RESULT_EXCE
//   TRAP  | result held, TRAP_REQ high until TRAP_ACK
module fpu_exception_responder (
    input  logic CLK,
    input  logic RST,
    fpu_exception_responder_if.slave bus
);

    localparam logic [2:0] EXCE_NONE  = 3'd0;
    localparam logic [2:0] EXCE_QNAN  = 3'd1;
    localparam logic [2:0] EXCE_SNAN  = 3'd2;
    localparam logic [2:0] EXCE_INF   = 3'd3;
    localparam logic [2:0] EXCE_ZDIV  = 3'd4;

    localparam logic [2:0] FLAG_INVALID  = 3'b001;
    localparam logic [2:0] FLAG_DIVZERO  = 3'b010;
    localparam logic [2:0] FLAG_NAN_PROP = 3'b100;

    localparam logic [7:0] CANON_QNAN = 8'h7C;
    localparam logic [7:0] QUIET_BIT  = 8'h04;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] result_q, result_d;
    logic [2:0] exce_q, exce_d;
    logic [2:0] flags_q, flags_d;
    logic [2:0] cause_q, cause_d;

    logic [7:0] resp_result;
    logic [2:0] resp_exce;
    logic [2:0] resp_raised;
    logic       op_a_is_nan;
    logic       op_a_is_zero;
    logic [7:0] nan_operand;
    logic       in_ready;
    logic       accept;
    logic       trap_hit;

    // The operation code does not influence the response; ZERO_DIV is already
    // only reported for divisions by the detector.
    logic unused_operation;
    assign unused_operation = ^bus.FP_OPERATION;

    assign op_a_is_nan  = (bus.OP_A[6:3] == 4'hF) && (bus.OP_A[2:0] != 3'b000);
    assign op_a_is_zero = (bus.OP_A[6:0] == 7'h00);
    assign nan_operand  = op_a_is_nan ? bus.OP_A : bus.OP_B;

    always_comb begin
        resp_result = bus.NORMAL_RESULT;
        resp_exce   = EXCE_NONE;
        resp_raised = 3'b000;
        if (bus.OP_IS_EXCEPTION) begin
            case (bus.FP_EXCE)
                EXCE_QNAN: begin
                    resp_result = nan_operand;
                    resp_exce   = EXCE_QNAN;
                    resp_raised = FLAG_NAN_PROP;
                end
                EXCE_SNAN: begin
                    resp_result = nan_operand | QUIET_BIT;
                    resp_exce   = EXCE_SNAN;
                    resp_raised = FLAG_INVALID;
                end
                EXCE_INF: begin
                    resp_result = CANON_QNAN;
                    resp_exce   = EXCE_INF;
                    resp_raised = FLAG_INVALID;
                end
                EXCE_ZDIV: begin
                    // 0/0 is an invalid operation, not a divide-by-zero.
                    if (op_a_is_zero) begin
                        resp_result = CANON_QNAN;
                        resp_exce   = EXCE_INF;
                        resp_raised = FLAG_INVALID;
                    end else begin
                        resp_result = {bus.OP_A[7] ^ bus.OP_B[7], 7'h78};
                        resp_exce   = EXCE_ZDIV;
                        resp_raised = FLAG_DIVZERO;
                    end
                end
                default: begin
                    resp_result = CANON_QNAN;
                    resp_exce   = EXCE_INF;
                    resp_raised = FLAG_INVALID;
                end
            endcase
        end
    end

    assign in_ready = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && bus.OUT_READY);
    assign accept   = bus.IN_VALID && in_ready;
    assign trap_hit = (resp_raised & bus.TRAP_EN) != 3'b000;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        exce_d   = exce_q;
        cause_d  = cause_q;
        // Clear first, then OR the new bits so a same-cycle raise survives.
        flags_d  = bus.FLAG_CLR ? 3'b000 : flags_q;

        if (accept) begin
            result_d = resp_result;
            exce_d   = resp_exce;
            flags_d  = flags_d | resp_raised;
            if (trap_hit) begin
                state_d = ST_TRAP;
                cause_d = resp_raised;
            end else begin
                state_d = ST_FULL;
            end
        end else begin
            case (state_q)
                ST_FULL:  if (bus.OUT_READY) state_d = ST_EMPTY;
                ST_TRAP:  if (bus.TRAP_ACK)  state_d = ST_FULL;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_EMPTY;
            result_q <= 8'h00;
            exce_q   <= EXCE_NONE;
            flags_q  <= 3'b000;
            cause_q  <= 3'b000;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            exce_q   <= exce_d;
            flags_q  <= flags_d;
            cause_q  <= cause_d;
        end
    end

    assign bus.IN_READY     = in_ready;
    assign bus.OUT_VALID    = (state_q == ST_FULL);
    assign bus.TRAP_REQ     = (state_q == ST_TRAP);
    assign bus.RESULT       = result_q;
    assign bus.RESULT_EXCE  = exce_q;
    assign bus.STICKY_FLAGS = flags_q;
    assign bus.TRAP_CAUSE   = cause_q;

endmodule

// File: tb/tb_fpu_exception_responder.sv
// Directed scenarios followed by a randomized stream checked against a
// queue-based reference model of the responder.
module tb_fpu_exception_responder;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   failures = 0;

    fpu_exception_responder_if bus();

    fpu_exception_responder dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_op(input logic v, input logic [7:0] a, input logic [7:0] b,
                            input logic exc, input logic [2:0] code, input logic [7:0] nr);
        bus.IN_VALID        = v;
        bus.FP_OPERATION    = 2'd3;
        bus.OP_A            = a;
        bus.OP_B            = b;
        bus.OP_IS_EXCEPTION = exc;
        bus.FP_EXCE         = code;
        bus.NORMAL_RESULT   = nr;
    endtask

    // Reference: a NaN has all-ones exponent and nonzero mantissa, i.e. its
    // magnitude is strictly above that of infinity (0x78).
    function automatic void ref_resp(input logic exc, input logic [2:0] code,
                                     input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] nr, output logic [7:0] res,
                                     output logic [2:0] ex, output logic [2:0] raised);
        int mag_a;
        mag_a = a & 8'h7F;
        if (!exc) begin
            res = nr; ex = 3'd0; raised = 3'd0;
        end else if (code == 3'd1) begin
            res = (mag_a > 8'h78) ? a : b; ex = 3'd1; raised = 3'd4;
        end else if (code == 3'd2) begin
            res = ((mag_a > 8'h78) ? a : b) + (((mag_a > 8'h78) ? a[2] : b[2]) ? 8'd0 : 8'd4);
            ex = 3'd2; raised = 3'd1;
        end else if (code == 3'd4 && mag_a != 0) begin
            res = ((a >= 8'h80) != (b >= 8'h80)) ? 8'hF8 : 8'h78; ex = 3'd4; raised = 3'd2;
        end else begin
            res = 8'h7C; ex = 3'd3; raised = 3'd1;
        end
    endfunction

    function automatic logic [7:0] pick_operand();
        case ($urandom_range(0, 8))
            0: return 8'h00;
            1: return 8'h80;
            2: return 8'h78;
            3: return 8'hF8;
            4: return 8'h79;
            5: return 8'hFE;
            6: return 8'h7C;
            7: return 8'h38;
            default: return 8'($urandom);
        endcase
    endfunction

    logic [10:0] q[$];
    logic [2:0]  mflags;
    logic [7:0]  r_res;
    logic [2:0]  r_ex, r_raised;
    logic        exp_ready;

    initial begin
        drive_op(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00);
        bus.OUT_READY = 1'b1;
        bus.FLAG_CLR  = 1'b0;
        bus.TRAP_EN   = 3'b000;
        bus.TRAP_ACK  = 1'b0;

        // reset state
        tick(); tick();
        chk("rst_out_valid", 8'(bus.OUT_VALID), 8'h0);
        chk("rst_result", bus.RESULT, 8'h00);
        chk("rst_exce", 8'(bus.RESULT_EXCE), 8'h0);
        chk("rst_flags", 8'(bus.STICKY_FLAGS), 8'h0);
        chk("rst_trap_req", 8'(bus.TRAP_REQ), 8'h0);
        chk("rst_cause", 8'(bus.TRAP_CAUSE), 8'h0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_in_ready", 8'(bus.IN_READY), 8'h1);

        // normal back-to-back stream
        for (int i = 1; i <= 4; i++) begin
            drive_op(1'b1, 8'h00, 8'h00, 1'b0, 3'd4, 8'(8'h11 * i));
            if (i == 1) chk("lat_before_accept", 8'(bus.OUT_VALID), 8'h0);
            tick();
            chk("stream_valid", 8'(bus.OUT_VALID), 8'h1);
            chk("stream_result", bus.RESULT, 8'(8'h11 * i));
            chk("stream_exce", 8'(bus.RESULT_EXCE), 8'h0);
        end
        drive_op(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00);
        tick();
        chk("stream_drain", 8'(bus.OUT_VALID), 8'h0);
        chk("stream_flags", 8'(bus.STICKY_FLAGS), 8'h0);

        // special results, flags accumulate
        drive_op(1'b1, 8'h79, 8'h10, 1'b1, 3'd2, 8'h00); tick();
        chk("snan_result", bus.RESULT, 8'h7D);
        chk("snan_exce", 8'(bus.RESULT_EXCE), 8'h2);
        chk("snan_flags", 8'(bus.STICKY_FLAGS), 8'h1);
        drive_op(1'b1, 8'h10, 8'hFE, 1'b1, 3'd1, 8'h00); tick();
        chk("qnan_result", bus.RESULT, 8'hFE);
        chk("qnan_exce", 8'(bus.RESULT_EXCE), 8'h1);
        chk("qnan_flags", 8'(bus.STICKY_FLAGS), 8'h5);
        drive_op(1'b1, 8'h38, 8'h80, 1'b1, 3'd4, 8'h00); tick();
        chk("divz_result", bus.RESULT, 8'hF8);
        chk("divz_exce", 8'(bus.RESULT_EXCE), 8'h4);
        chk("divz_flags", 8'(bus.STICKY_FLAGS), 8'h7);
        drive_op(1'b1, 8'h00, 8'h00, 1'b1, 3'd4, 8'h00); tick();
        chk("zz_result", bus.RESULT, 8'h7C);
        chk("zz_exce", 8'(bus.RESULT_EXCE), 8'h3);
        drive_op(1'b1, 8'h12, 8'h34, 1'b1, 3'd6, 8'h00); tick();
        chk("rsvd_result", bus.RESULT, 8'h7C);
        chk("rsvd_exce", 8'(bus.RESULT_EXCE), 8'h3);
        drive_op(1'b1, 8'h00, 8'h00, 1'b1, 3'd3, 8'h00); tick();
        chk("inf_result", bus.RESULT, 8'h7C);
        drive_op(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00);
        bus.FLAG_CLR = 1'b1; tick(); bus.FLAG_CLR = 1'b0;
        chk("clr_flags", 8'(bus.STICKY_FLAGS), 8'h0);

        // backpressure
        bus.OUT_READY = 1'b0;
        drive_op(1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 8'hA1); tick();
        drive_op(1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 8'hB2);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 8'(bus.IN_READY), 8'h0);
            tick();
            chk("bp_valid", 8'(bus.OUT_VALID), 8'h1);
            chk("bp_result", bus.RESULT, 8'hA1);
        end
        bus.OUT_READY = 1'b1;
        #1;
        chk("bp_release_ready", 8'(bus.IN_READY), 8'h1);
        tick();
        chk("bp_next_result", bus.RESULT, 8'hB2);
        chk("bp_next_valid", 8'(bus.OUT_VALID), 8'h1);
        drive_op(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00); tick();
        chk("bp_drain", 8'(bus.OUT_VALID), 8'h0);

        // trap on divide-by-zero
        bus.TRAP_EN = 3'b010;
        drive_op(1'b1, 8'h38, 8'h00, 1'b1, 3'd4, 8'h00); tick();
        drive_op(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00);
        chk("trap_req", 8'(bus.TRAP_REQ), 8'h1);
        chk("trap_cause", 8'(bus.TRAP_CAUSE), 8'h2);
        chk("trap_flags", 8'(bus.STICKY_FLAGS), 8'h2);
        for (int i = 0; i < 5; i++) begin
            chk("trap_hold_valid", 8'(bus.OUT_VALID), 8'h0);
            chk("trap_hold_ready", 8'(bus.IN_READY), 8'h0);
            chk("trap_hold_req", 8'(bus.TRAP_REQ), 8'h1);
            tick();
        end
        bus.TRAP_ACK = 1'b1; tick(); bus.TRAP_ACK = 1'b0;
        chk("trap_ack_valid", 8'(bus.OUT_VALID), 8'h1);
        chk("trap_ack_result", bus.RESULT, 8'h78);
        chk("trap_ack_req", 8'(bus.TRAP_REQ), 8'h0);
        chk("trap_cause_hold", 8'(bus.TRAP_CAUSE), 8'h2);
        tick();
        chk("trap_drain", 8'(bus.OUT_VALID), 8'h0);

        // flag clear vs same-cycle raise
        bus.TRAP_EN = 3'b000;
        bus.FLAG_CLR = 1'b1;
        drive_op(1'b1, 8'h00, 8'h00, 1'b1, 3'd3, 8'h00); tick();
        drive_op(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00);
        chk("clr_set_wins", 8'(bus.STICKY_FLAGS), 8'h1);
        tick(); bus.FLAG_CLR = 1'b0;
        chk("clr_alone", 8'(bus.STICKY_FLAGS), 8'h0);

        // reset during trap
        bus.TRAP_EN = 3'b001;
        drive_op(1'b1, 8'h79, 8'h00, 1'b1, 3'd2, 8'h00); tick();
        drive_op(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00);
        chk("rtrap_req", 8'(bus.TRAP_REQ), 8'h1);
        RST = 1'b1;
        #1;
        chk("rtrap_req_cleared", 8'(bus.TRAP_REQ), 8'h0);
        chk("rtrap_valid", 8'(bus.OUT_VALID), 8'h0);
        chk("rtrap_flags", 8'(bus.STICKY_FLAGS), 8'h0);
        chk("rtrap_cause", 8'(bus.TRAP_CAUSE), 8'h0);
        bus.TRAP_EN = 3'b000;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rtrap_in_ready", 8'(bus.IN_READY), 8'h1);
        tick();

        // randomized stream against the queue model
        mflags = 3'b000;
        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("rnd_valid", 8'(bus.OUT_VALID), 8'(q.size() != 0));
            if (q.size() != 0) begin
                chk("rnd_result", bus.RESULT, q[0][10:3]);
                chk("rnd_exce", 8'(bus.RESULT_EXCE), 8'(q[0][2:0]));
            end
            chk("rnd_flags", 8'(bus.STICKY_FLAGS), 8'(mflags));

            drive_op(1'($urandom_range(0, 3) != 0), pick_operand(), pick_operand(),
                     1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom));
            bus.OUT_READY = 1'($urandom_range(0, 3) != 0);
            bus.FLAG_CLR  = 1'($urandom_range(0, 9) == 0);
            #1;
            exp_ready = (q.size() == 0) || bus.OUT_READY;
            chk("rnd_in_ready", 8'(bus.IN_READY), 8'(exp_ready));

            ref_resp(bus.OP_IS_EXCEPTION, bus.FP_EXCE, bus.OP_A, bus.OP_B,
                     bus.NORMAL_RESULT, r_res, r_ex, r_raised);
            if (q.size() != 0 && bus.OUT_READY) void'(q.pop_front());
            if (bus.FLAG_CLR) mflags = 3'b000;
            if (bus.IN_VALID && exp_ready) begin
                q.push_back({r_res, r_ex});
                mflags = mflags | r_raised;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
